// File: rtl/core_issue_window_pkg.sv
// Shared decode helpers and types for the TOY core issue window.
// Instruction layout: op[15:12], rd[11:8], rs[7:4], rt[3:0].
package core_pkg;

    typedef enum logic [3:0] {
        OP_HALT = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLT  = 4'h6,
        OP_LI   = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_LDX  = 4'ha,
        OP_STX  = 4'hb,
        OP_BEQZ = 4'hc,
        OP_BNEZ = 4'hd,
        OP_JR   = 4'he,
        OP_JAL  = 4'hf
    } op_e;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_CTRL = 2'd1,
        HALTED    = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } entry_t;

    localparam int NREGS = 16;

    function automatic logic reads_rs(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
    endfunction

    function automatic logic reads_rt(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LDX, OP_STX};
    endfunction

    function automatic logic reads_rd(input op_e op);
        return op inside {OP_ST, OP_STX, OP_BEQZ, OP_BNEZ, OP_JR};
    endfunction

    function automatic logic writes_rd(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                          OP_LI, OP_LD, OP_LDX, OP_JAL};
    endfunction

    function automatic logic is_mem(input op_e op);
        return op inside {OP_LD, OP_ST, OP_LDX, OP_STX};
    endfunction

    function automatic logic is_ctrl(input op_e op);
        return op inside {OP_BEQZ, OP_BNEZ, OP_JR, OP_JAL};
    endfunction

endpackage

// File: rtl/core_issue_window_if.sv
// Fetch-side and issue-side lanes of the issue window, lane 0 is the oldest.
interface core_issue_window_if #(
    parameter int ISSUE_W = 2
);
    logic [ISSUE_W-1:0]       in_valid_i;
    logic [ISSUE_W-1:0][15:0] in_instr_i;
    logic [ISSUE_W-1:0][7:0]  in_pc_i;
    logic                     in_ready_o;
    logic [ISSUE_W-1:0]       iss_valid_o;
    logic [ISSUE_W-1:0][15:0] iss_instr_o;
    logic [ISSUE_W-1:0][7:0]  iss_pc_o;

    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i,
        output in_ready_o, iss_valid_o, iss_instr_o, iss_pc_o
    );

    modport master (
        output in_valid_i, in_instr_i, in_pc_i,
        input  in_ready_o, iss_valid_o, iss_instr_o, iss_pc_o
    );
endinterface

// File: rtl/core_issue_window_queue.sv
// Circular instruction FIFO: ISSUE_W push lanes, 0..ISSUE_W pop per edge, flush.
// Pointers carry one extra bit so full and empty are distinguishable.
module core_issue_queue
    import core_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int ISSUE_W = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = AW + 1,
    localparam int CW      = $clog2(ISSUE_W + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush,
    input  logic [CW-1:0]              push_cnt,
    input  entry_t [ISSUE_W-1:0]       push_data,
    input  logic [CW-1:0]              pop_cnt,
    output entry_t [ISSUE_W-1:0]       head,
    output logic [PW-1:0]              count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    entry_t        mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_cnt);
            rd_ptr <= rd_ptr + PW'(pop_cnt);
        end
    end

    // Storage is data only; validity comes entirely from the pointers.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ISSUE_W; i++) begin
            if (!flush && (CW'(i) < push_cnt))
                mem[wr_ptr[AW-1:0] + AW'(i)] <= push_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++)
            head[i] = mem[rd_ptr[AW-1:0] + AW'(i)];
    end

    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/core_issue_window.sv
// In-order multi-issue front end: queue, dirty-register scoreboard, LSU slot
// tracking and control-flow serialisation FSM.
module core_issue_window
    import core_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2,
    parameter int WB_W    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    core_issue_window_if.slave       io,
    input  logic [WB_W-1:0]          wb_en_i,
    input  logic [WB_W-1:0][3:0]     wb_addr_i,
    input  logic                     lsu_done_i,
    input  logic                     ctrl_done_i,
    input  logic                     ctrl_taken_i,
    output logic                     halted_o,
    output logic [NREGS-1:0]         dirty_o
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(ISSUE_W + 1);

    state_e               state_q, state_d;
    logic [NREGS-1:0]     dirty_q, dirty_d, clr_mask, set_mask, use_mask;
    logic                 lsu_busy_q;
    logic                 flush;
    entry_t [ISSUE_W-1:0] head, push_data;
    logic [PW-1:0]        count;
    logic [CW-1:0]        push_cnt, pop_cnt;
    logic [ISSUE_W-1:0]   iss_ok;
    logic                 go, stall, grp_mem, grp_stop;
    logic                 issue_ctrl, issue_halt, issue_mem;
    logic                 ready;
    op_e                  op;
    logic [3:0]           rd, rs, rt;

    core_issue_queue #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W)) u_queue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (flush),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .head      (head),
        .count     (count)
    );

    assign ready = (state_q != HALTED) && ((PW'(DEPTH) - count) >= PW'(ISSUE_W));

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            push_data[i] = '{pc: io.in_pc_i[i], instr: io.in_instr_i[i]};
            if (io.in_valid_i[i] && ready && !flush && !rst_i)
                push_cnt = push_cnt + CW'(1);
        end
    end

    // Age-ordered scan: the first stalled slot ends the group.
    always_comb begin
        iss_ok     = '0;
        pop_cnt    = '0;
        set_mask   = '0;
        grp_mem    = 1'b0;
        grp_stop   = 1'b0;
        issue_ctrl = 1'b0;
        issue_halt = 1'b0;
        issue_mem  = 1'b0;
        use_mask   = '0;
        stall      = 1'b0;
        op         = OP_HALT;
        rd         = '0;
        rs         = '0;
        rt         = '0;
        go         = (state_q == RUN);
        for (int k = 0; k < ISSUE_W; k++) begin
            op       = op_e'(head[k].instr[15:12]);
            rd       = head[k].instr[11:8];
            rs       = head[k].instr[7:4];
            rt       = head[k].instr[3:0];
            use_mask = '0;
            if (reads_rs(op))                 use_mask[rs] = 1'b1;
            if (reads_rt(op))                 use_mask[rt] = 1'b1;
            if (reads_rd(op) || writes_rd(op)) use_mask[rd] = 1'b1;
            use_mask[0] = 1'b0;
            stall = |(use_mask & (dirty_q | set_mask));
            if (is_mem(op) && (lsu_busy_q || grp_mem))
                stall = 1'b1;
            if (op == OP_HALT && (k != 0 || dirty_q != '0 || lsu_busy_q))
                stall = 1'b1;
            go = go && (count > PW'(k)) && !stall && !grp_stop;
            if (go) begin
                iss_ok[k] = 1'b1;
                pop_cnt   = pop_cnt + CW'(1);
                if (writes_rd(op) && rd != 4'd0)
                    set_mask[rd] = 1'b1;
                if (is_mem(op)) begin
                    grp_mem   = 1'b1;
                    issue_mem = 1'b1;
                end
                if (is_ctrl(op) || op == OP_HALT)
                    grp_stop = 1'b1;
                if (is_ctrl(op))
                    issue_ctrl = 1'b1;
                if (op == OP_HALT)
                    issue_halt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (issue_halt)      state_d = HALTED;
                else if (issue_ctrl) state_d = WAIT_CTRL;
            end
            WAIT_CTRL: begin
                if (ctrl_done_i) begin
                    state_d = RUN;
                    flush   = ctrl_taken_i;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // A set from this edge's issue overrides a writeback clear of the same register.
    always_comb begin
        clr_mask = '0;
        for (int w = 0; w < WB_W; w++)
            if (wb_en_i[w]) clr_mask[wb_addr_i[w]] = 1'b1;
        dirty_d    = (dirty_q & ~clr_mask) | set_mask;
        dirty_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dirty_q    <= '0;
            lsu_busy_q <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
            if (issue_mem)       lsu_busy_q <= 1'b1;
            else if (lsu_done_i) lsu_busy_q <= 1'b0;
        end
    end

    always_comb begin
        io.in_ready_o  = ready && !rst_i;
        io.iss_valid_o = rst_i ? '0 : iss_ok;
        for (int k = 0; k < ISSUE_W; k++) begin
            io.iss_instr_o[k] = head[k].instr;
            io.iss_pc_o[k]    = head[k].pc;
        end
    end

    assign halted_o = (state_q == HALTED) && !rst_i;
    assign dirty_o  = rst_i ? '0 : dirty_q;

endmodule

// File: tb/tb_core_issue_window.sv
// Directed bench for core_issue_window: a table of two-lane fetch groups
// followed by hand-written multi-cycle sequences.
module tb_core_issue_window;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      wb_en = '0;
    logic [1:0][3:0] wb_addr = '0;
    logic            lsu_done = 1'b0;
    logic            ctrl_done = 1'b0;
    logic            ctrl_taken = 1'b0;
    logic            halted;
    logic [15:0]     dirty;

    int n_tests = 0;
    int n_fail  = 0;

    core_issue_window_if #(.ISSUE_W(2)) bus ();

    core_issue_window #(.DEPTH(8), .ISSUE_W(2), .WB_W(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .io           (bus),
        .wb_en_i      (wb_en),
        .wb_addr_i    (wb_addr),
        .lsu_done_i   (lsu_done),
        .ctrl_done_i  (ctrl_done),
        .ctrl_taken_i (ctrl_taken),
        .halted_o     (halted),
        .dirty_o      (dirty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] i0;
        logic [15:0] i1;
        logic [1:0]  exp_v;
        logic [15:0] exp_dirty;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid_i = '0;
        wb_en = '0;
        lsu_done = 1'b0;
        ctrl_done = 1'b0;
        ctrl_taken = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready_o), 0);
        check("rst_iss_valid", 32'(bus.iss_valid_o), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_dirty", 32'(dirty), 0);
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1,
                        input logic [7:0] pc0);
        bus.in_valid_i    = v;
        bus.in_instr_i[0] = i0;
        bus.in_instr_i[1] = i1;
        bus.in_pc_i[0]    = pc0;
        bus.in_pc_i[1]    = pc0 + 8'd1;
        step();
        bus.in_valid_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid_i = '0;
        bus.in_instr_i = '0;
        bus.in_pc_i    = '0;

        vecs.push_back('{"raw_same_group", 16'h1123, 16'h1415, 2'b01, 16'h0002});
        vecs.push_back('{"dual_indep",     16'h1123, 16'h2456, 2'b11, 16'h0012});
        vecs.push_back('{"two_mem",        16'h8110, 16'h8220, 2'b01, 16'h0002});
        vecs.push_back('{"ctrl_lane0",     16'hC120, 16'h1123, 2'b01, 16'h0000});
        vecs.push_back('{"halt_lane1",     16'h1123, 16'h0000, 2'b01, 16'h0002});
        vecs.push_back('{"r0_writer",      16'h7005, 16'h1200, 2'b11, 16'h0004});
        vecs.push_back('{"waw_same_group", 16'h1123, 16'h2156, 2'b01, 16'h0002});
        vecs.push_back('{"ctrl_lane1",     16'h1123, 16'hC450, 2'b11, 16'h0002});
        vecs.push_back('{"ldx_then_st",    16'hA120, 16'h9340, 2'b01, 16'h0002});
        vecs.push_back('{"halt_clean",     16'h0000, 16'h1123, 2'b01, 16'h0000});
        vecs.push_back('{"stx_then_alu",   16'hB312, 16'h1123, 2'b11, 16'h0002});

        @(negedge clk);
        do_reset();
        check("ready_after_reset", 32'(bus.in_ready_o), 1);

        foreach (vecs[i]) begin
            do_reset();
            push(2'b11, vecs[i].i0, vecs[i].i1, 8'(8'h10 * i));
            check({vecs[i].name, "_valid"}, 32'(bus.iss_valid_o), 32'(vecs[i].exp_v));
            check({vecs[i].name, "_instr0"}, 32'(bus.iss_instr_o[0]), 32'(vecs[i].i0));
            check({vecs[i].name, "_pc0"}, 32'(bus.iss_pc_o[0]), 32'(8'(8'h10 * i)));
            if (vecs[i].exp_v[1])
                check({vecs[i].name, "_instr1"}, 32'(bus.iss_instr_o[1]), 32'(vecs[i].i1));
            check({vecs[i].name, "_dirty_pre"}, 32'(dirty), 0);
            step();
            check({vecs[i].name, "_dirty_post"}, 32'(dirty), 32'(vecs[i].exp_dirty));
        end

        // RAW released by writeback one cycle later
        do_reset();
        push(2'b11, 16'h1123, 16'h1415, 8'h00);
        step();
        check("raw_held", 32'(bus.iss_valid_o), 0);
        wb_en = 2'b01;
        wb_addr[0] = 4'd1;
        step();
        wb_en = '0;
        check("raw_release_valid", 32'(bus.iss_valid_o), 1);
        check("raw_release_instr", 32'(bus.iss_instr_o[0]), 32'h1415);

        // LSU serialisation
        do_reset();
        push(2'b11, 16'h8110, 16'h8220, 8'h00);
        step();
        check("lsu_busy_hold0", 32'(bus.iss_valid_o), 0);
        step();
        check("lsu_busy_hold1", 32'(bus.iss_valid_o), 0);
        lsu_done = 1'b1;
        step();
        lsu_done = 1'b0;
        check("lsu_release_valid", 32'(bus.iss_valid_o), 1);
        check("lsu_release_instr", 32'(bus.iss_instr_o[0]), 32'h8220);

        // Taken branch flushes queue and the group arriving on the flush edge
        do_reset();
        push(2'b11, 16'hC120, 16'h1123, 8'h00);
        step();
        check("wait_ctrl_no_issue", 32'(bus.iss_valid_o), 0);
        ctrl_done = 1'b1;
        ctrl_taken = 1'b1;
        bus.in_valid_i = 2'b11;
        bus.in_instr_i[0] = 16'h2456;
        bus.in_instr_i[1] = 16'h2456;
        step();
        ctrl_done = 1'b0;
        ctrl_taken = 1'b0;
        bus.in_valid_i = '0;
        check("taken_flush_valid", 32'(bus.iss_valid_o), 0);
        check("taken_flush_ready", 32'(bus.in_ready_o), 1);
        step();
        check("taken_flush_stays_empty", 32'(bus.iss_valid_o), 0);
        check("taken_flush_dirty", 32'(dirty), 0);

        // Not-taken branch: next instruction issues one cycle after resolve
        do_reset();
        push(2'b11, 16'hC120, 16'h1123, 8'h00);
        step();
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        check("not_taken_valid", 32'(bus.iss_valid_o), 1);
        check("not_taken_instr", 32'(bus.iss_instr_o[0]), 32'h1123);

        // Halt waits for a clean scoreboard, then freezes until reset
        do_reset();
        push(2'b11, 16'h1123, 16'h0000, 8'h00);
        step();
        check("halt_wait_dirty0", 32'(bus.iss_valid_o), 0);
        step();
        check("halt_wait_dirty1", 32'(bus.iss_valid_o), 0);
        wb_en = 2'b01;
        wb_addr[0] = 4'd1;
        step();
        wb_en = '0;
        check("halt_issue_valid", 32'(bus.iss_valid_o), 1);
        check("halt_issue_instr", 32'(bus.iss_instr_o[0]), 32'h0000);
        step();
        check("halted_flag", 32'(halted), 1);
        check("halted_ready", 32'(bus.in_ready_o), 0);
        check("halted_no_issue", 32'(bus.iss_valid_o), 0);
        bus.in_valid_i = 2'b11;
        bus.in_instr_i[0] = 16'h2456;
        step();
        bus.in_valid_i = '0;
        check("halted_still", 32'(halted), 1);
        check("halted_ignores_fetch", 32'(bus.iss_valid_o), 0);
        do_reset();
        check("halt_cleared", 32'(halted), 0);
        check("halt_ready_again", 32'(bus.in_ready_o), 1);

        // Fill to DEPTH while waiting on a branch
        do_reset();
        push(2'b01, 16'hC120, 16'h0000, 8'h00);
        check("fill_ctrl_issue", 32'(bus.iss_valid_o), 1);
        step();
        for (int g = 0; g < 4; g++) begin
            check("fill_ready", 32'(bus.in_ready_o), 1);
            push(2'b11, 16'h1123, 16'h2456, 8'(g * 2));
        end
        check("full_not_ready", 32'(bus.in_ready_o), 0);
        check("full_no_issue", 32'(bus.iss_valid_o), 0);
        ctrl_done = 1'b1;
        ctrl_taken = 1'b1;
        step();
        ctrl_done = 1'b0;
        ctrl_taken = 1'b0;
        check("full_flush_ready", 32'(bus.in_ready_o), 1);
        check("full_flush_empty", 32'(bus.iss_valid_o), 0);

        // Writeback and issue of R3 on the same edge: set wins
        do_reset();
        push(2'b01, 16'h1300, 16'h0000, 8'h00);
        check("r3_issue", 32'(bus.iss_valid_o), 1);
        wb_en = 2'b01;
        wb_addr[0] = 4'd3;
        step();
        wb_en = '0;
        check("r3_set_wins", 32'(dirty), 32'h0008);
        wb_en = 2'b10;
        wb_addr[1] = 4'd3;
        step();
        wb_en = '0;
        check("r3_wb_port1_clears", 32'(dirty), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
